// File: rtl/decoder_seq_n_pkg.sv
// Shared types and the one-hot helper for the decoder_seq_n block.
// The helper is sized for the widest supported select; callers slice it down.
package dec_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int SEL_W_MAX = 8;
    localparam int OUT_W_MAX = 2 ** SEL_W_MAX;

    function automatic logic [OUT_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel,
                                                     input logic                 en);
        logic [OUT_W_MAX-1:0] v;
        v = {OUT_W_MAX{1'b0}};
        if (en) begin
            v[sel] = 1'b1;
        end else begin
            v = {OUT_W_MAX{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_seq_n_if.sv
// Control/select/result bundle for decoder_seq_n.
// The scan_dir member exists only when DECODER_REVERSE_SCAN_EN is defined.
interface decoder_seq_n_if #(parameter int SEL_W = 5);

    localparam int OUT_W = 2 ** SEL_W;

    logic             en;
    logic [SEL_W-1:0] S;
    logic             start;
    logic             stall;
    logic             abort;
`ifdef DECODER_REVERSE_SCAN_EN
    logic             scan_dir;
`endif
    logic [OUT_W-1:0] m;
    logic [SEL_W-1:0] sel_q;
    logic             busy;
    logic             done;

`ifdef DECODER_REVERSE_SCAN_EN
    modport master (output en, S, start, stall, abort, scan_dir,
                    input  m, sel_q, busy, done);
    modport slave  (input  en, S, start, stall, abort, scan_dir,
                    output m, sel_q, busy, done);
`else
    modport master (output en, S, start, stall, abort,
                    input  m, sel_q, busy, done);
    modport slave  (input  en, S, start, stall, abort,
                    output m, sel_q, busy, done);
`endif

endinterface

// File: rtl/decoder_seq_n_onehot.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable (module dec_onehot).
module dec_onehot
    import dec_pkg::*;
#(
    parameter int SEL_W = 5
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   m
);

    localparam int OUT_W = 2 ** SEL_W;

    logic [SEL_W_MAX-1:0] sel_ext_s;
    logic [OUT_W_MAX-1:0] full_s;
    logic                 unused_full_s;

    // Widen the select, decode at maximum width, keep the low OUT_W bits.
    always_comb begin
        sel_ext_s                = {SEL_W_MAX{1'b0}};
        sel_ext_s[SEL_W-1:0]     = sel;
        full_s                   = onehot(sel_ext_s, en);
        m                        = full_s[OUT_W-1:0];
    end

    assign unused_full_s = ^full_s;

endmodule

// File: rtl/decoder_seq_n.sv
// Registered N-to-2**N one-hot decoder with a scan sequencer (IDLE/SCAN FSM).
// Optional descending scan: define DECODER_REVERSE_SCAN_EN to add bus.scan_dir.
module decoder_seq_n
    import dec_pkg::*;
#(
    parameter int SEL_W = 5,
    parameter bit PULSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    decoder_seq_n_if.slave        bus
);

    localparam int               OUT_W     = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_FIRST = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W-1:0] IDX_ONE   = SEL_W'(1);

    state_t             state_r, state_s;
    logic [SEL_W-1:0]   sel_q_r, idx_s;
    logic [OUT_W-1:0]   m_r, m_s;
    logic               hot_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [SEL_W-1:0]   end_idx_s, step_idx_s, start_idx_s;
    logic               dir_r, dir_s;

    // Direction-dependent scan endpoints and step.
    always_comb begin
`ifdef DECODER_REVERSE_SCAN_EN
        if (dir_r) begin
            end_idx_s  = IDX_FIRST;
            step_idx_s = sel_q_r - IDX_ONE;
        end else begin
            end_idx_s  = IDX_LAST;
            step_idx_s = sel_q_r + IDX_ONE;
        end
        if (bus.scan_dir) begin
            start_idx_s = IDX_LAST;
        end else begin
            start_idx_s = IDX_FIRST;
        end
        dir_s = dir_r;
        if (state_r == ST_IDLE && bus.start) begin
            dir_s = bus.scan_dir;
        end else begin
            dir_s = dir_r;
        end
`else
        end_idx_s   = IDX_LAST;
        step_idx_s  = sel_q_r + IDX_ONE;
        start_idx_s = IDX_FIRST;
        dir_s       = 1'b0;
`endif
    end

    // Next-state, next index and next output-enable decision.
    always_comb begin
        state_s = state_r;
        idx_s   = sel_q_r;
        hot_s   = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SCAN;
                    idx_s   = start_idx_s;
                    hot_s   = 1'b1;
                    busy_s  = 1'b1;
                end else if (bus.en) begin
                    idx_s   = bus.S;
                    hot_s   = 1'b1;
                end else if (PULSE) begin
                    hot_s   = 1'b0;
                end else begin
                    // Held mode: re-decode the same index only if m is currently lit.
                    hot_s   = |m_r;
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (bus.stall) begin
                    hot_s   = 1'b1;
                    busy_s  = 1'b1;
                end else if (sel_q_r == end_idx_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    idx_s   = step_idx_s;
                    hot_s   = 1'b1;
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    dec_onehot #(.SEL_W(SEL_W)) u_onehot (
        .en  (hot_s),
        .sel (idx_s),
        .m   (m_s)
    );

    // State, index, output and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_q_r <= {SEL_W{1'b0}};
            m_r     <= {OUT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dir_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            sel_q_r <= idx_s;
            m_r     <= m_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            dir_r   <= dir_s;
        end
    end

    assign bus.m     = m_r;
    assign bus.sel_q = sel_q_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_decoder_seq_n.sv
// Directed scoreboard bench for decoder_seq_n (PULSE=1 and PULSE=0 instances, SEL_W=5).
module tb_decoder_seq_n;
    import dec_pkg::*;

    typedef struct packed {
        logic [31:0] m;
        logic [4:0]  sel;
        logic        busy;
        logic        done;
        logic [31:0] m0;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    decoder_seq_n_if #(.SEL_W(5)) if1 ();
    decoder_seq_n_if #(.SEL_W(5)) if0 ();

    assign if0.en    = if1.en;
    assign if0.S     = if1.S;
    assign if0.start = if1.start;
    assign if0.stall = if1.stall;
    assign if0.abort = if1.abort;
`ifdef DECODER_REVERSE_SCAN_EN
    assign if0.scan_dir = if1.scan_dir;
`endif

    decoder_seq_n #(.SEL_W(5), .PULSE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    decoder_seq_n #(.SEL_W(5), .PULSE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic cyc(input logic r, input logic e, input logic [4:0] s,
                       input logic st, input logic sl, input logic ab,
                       input logic [31:0] xm, input logic [4:0] xs,
                       input logic xb, input logic xd, input logic [31:0] xm0);
        exp_t x;
        rst       = r;
        if1.en    = e;
        if1.S     = s;
        if1.start = st;
        if1.stall = sl;
        if1.abort = ab;
        x.m = xm; x.sel = xs; x.busy = xb; x.done = xd; x.m0 = xm0;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        step_no++;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_empty step=%0d observed=0 expected=1", step_no);
        end else begin
            x = sb_q.pop_front();
            check("m",       if1.m,                   x.m);
            check("sel_q",   {27'd0, if1.sel_q},      {27'd0, x.sel});
            check("busy",    {31'd0, if1.busy},       {31'd0, x.busy});
            check("done",    {31'd0, if1.done},       {31'd0, x.done});
            check("m_held",  if0.m,                   x.m0);
            check("done_held", {31'd0, if0.done},     {31'd0, x.done});
        end
    endtask

    initial begin
        logic [31:0] oh;
        rst = 1'b1;
        if1.en = 1'b0; if1.S = 5'd0; if1.start = 1'b0; if1.stall = 1'b0; if1.abort = 1'b0;
`ifdef DECODER_REVERSE_SCAN_EN
        if1.scan_dir = 1'b0;
`endif
        // Reset, then en/S=7 on the release cycle
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 32'h80, 5'd7, 1'b0, 1'b0, 32'h80);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd7, 1'b0, 1'b0, 32'h80);
        // Top index: pulse vs held
        cyc(1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
        cyc(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h8, 5'd3, 1'b0, 1'b0, 32'h8);
        // Full scan; start collides with en/S=3, en/S=5 mid-scan is ignored
        cyc(1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h1, 5'd0, 1'b1, 1'b0, 32'h1);
        for (int i = 1; i < 32; i++) begin
            oh = 32'd1 << i;
            if (i == 5) begin
                cyc(1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, oh, 5'(i), 1'b1, 1'b0, oh);
            end else begin
                cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, oh, 5'(i), 1'b1, 1'b0, oh);
            end
        end
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd31, 1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd31, 1'b0, 1'b0, 32'h0);
        // Stall at 10 for 3 cycles, then abort (with stall) at 12
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h1, 5'd0, 1'b1, 1'b0, 32'h1);
        for (int i = 1; i <= 10; i++) begin
            oh = 32'd1 << i;
            cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, oh, 5'(i), 1'b1, 1'b0, oh);
        end
        repeat (3) cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h400, 5'd10, 1'b1, 1'b0, 32'h400);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h800, 5'd11, 1'b1, 1'b0, 32'h800);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h1000, 5'd12, 1'b1, 1'b0, 32'h1000);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 5'd12, 1'b0, 1'b0, 32'h0);
        repeat (3) cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd12, 1'b0, 1'b0, 32'h0);
        // Reset at index 20 beats a concurrent start
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h1, 5'd0, 1'b1, 1'b0, 32'h1);
        for (int i = 1; i <= 20; i++) begin
            oh = 32'd1 << i;
            cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, oh, 5'(i), 1'b1, 1'b0, oh);
        end
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
`ifdef DECODER_REVERSE_SCAN_EN
        // Descending scan; scan_dir dropped after start must not matter
        if1.scan_dir = 1'b1;
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h8000_0000);
        if1.scan_dir = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            oh = 32'd1 << i;
            cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, oh, 5'(i), 1'b1, 1'b0, oh);
        end
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
